// File: rtl/wb_route_pkg.sv
// Shared types and register layout for the Wishbone route controller.
// Holds the FSM encoding, config/status bit positions and the readback formatter.
package wb_route_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCAL = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CFG_SEL_LSB    = 0;
    localparam int CFG_SEL_W      = 4;
    localparam int CFG_TOFLAG_BIT = 8;

    localparam logic [CFG_SEL_W-1:0] CFG_SEL_MAX = 4'd3;

    function automatic logic [31:0] cfg_readback(input logic toflag,
                                                 input logic [CFG_SEL_W-1:0] sel);
        logic [31:0] r;
        r = '0;
        r[CFG_SEL_LSB +: CFG_SEL_W] = sel;
        r[CFG_TOFLAG_BIT]           = toflag;
        return r;
    endfunction

endpackage

// File: rtl/wb_route_timer.sv
// Clearable saturating up-counter; tc_o is high while the count equals TIMEOUT-1.
// Latency: count advances one per enabled cycle; no backpressure, clear dominates enable.
module wb_route_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != MAX_VAL)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/wb_route_ctrl.sv
// Wishbone front-end to bot_h_line: local config/status register, registered forwarding, ack timeout.
// Latency: local ack 1 cycle after sampling, forwarded ack 1 cycle after tile ack; one transaction in flight.
module wb_route_ctrl
    import wb_route_pkg::*;
#(
    parameter logic [31:0] CFG_ADDR  = 32'h3000_FFFC,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] TO_DATA   = 32'hDEAD_BEEF,
    parameter logic [3:0]  CFG_RESET = 4'd0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        m_stb_o,
    output logic        m_cyc_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_dat_o,
    output logic [31:0] m_adr_o,
    input  logic        m_ack_i,
    input  logic [31:0] m_dat_i,
    output logic [3:0]  configuration,
    output logic        timeout_flag
);

    state_t               state_q;
    logic                 ack_q;
    logic [31:0]          rdat_q;
    logic                 m_cyc_q;
    logic                 m_stb_q;
    logic                 m_we_q;
    logic [3:0]           m_sel_q;
    logic [31:0]          m_dat_q;
    logic [31:0]          m_adr_q;
    logic [CFG_SEL_W-1:0] cfg_q;
    logic                 toflag_q;

    logic req_vld;
    logic tmr_tc;
    logic cfg_wr_ok;

    assign req_vld   = wbs_cyc_i & wbs_stb_i;
    assign cfg_wr_ok = (wbs_dat_i[CFG_SEL_LSB +: CFG_SEL_W] <= CFG_SEL_MAX);

    wb_route_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .clr_i (state_q != WAIT),
        .en_i  (state_q == WAIT),
        .tc_o  (tmr_tc)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            rdat_q   <= '0;
            m_cyc_q  <= 1'b0;
            m_stb_q  <= 1'b0;
            m_we_q   <= 1'b0;
            m_sel_q  <= '0;
            m_dat_q  <= '0;
            m_adr_q  <= '0;
            cfg_q    <= CFG_RESET;
            toflag_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_vld) begin
                        if (wbs_adr_i == CFG_ADDR) begin
                            // Register updates land on the same edge that raises ack.
                            ack_q  <= 1'b1;
                            rdat_q <= cfg_readback(toflag_q, cfg_q);
                            if (wbs_we_i && wbs_sel_i[0] && cfg_wr_ok) begin
                                cfg_q <= wbs_dat_i[CFG_SEL_LSB +: CFG_SEL_W];
                            end
                            if (wbs_we_i && wbs_sel_i[1] && wbs_dat_i[CFG_TOFLAG_BIT]) begin
                                toflag_q <= 1'b0;
                            end
                            state_q <= LOCAL;
                        end else begin
                            m_cyc_q <= 1'b1;
                            m_stb_q <= 1'b1;
                            m_we_q  <= wbs_we_i;
                            m_sel_q <= wbs_sel_i;
                            m_dat_q <= wbs_dat_i;
                            m_adr_q <= wbs_adr_i;
                            state_q <= WAIT;
                        end
                    end
                end
                LOCAL, DONE: begin
                    ack_q   <= 1'b0;
                    rdat_q  <= '0;
                    state_q <= IDLE;
                end
                WAIT: begin
                    if (!wbs_cyc_i || m_ack_i || tmr_tc) begin
                        m_cyc_q <= 1'b0;
                        m_stb_q <= 1'b0;
                        m_we_q  <= 1'b0;
                        m_sel_q <= '0;
                        m_dat_q <= '0;
                        m_adr_q <= '0;
                    end
                    // Upstream abort wins; otherwise a tile ack beats a same-cycle timeout.
                    if (!wbs_cyc_i) begin
                        state_q <= IDLE;
                    end else if (m_ack_i) begin
                        ack_q   <= 1'b1;
                        rdat_q  <= m_dat_i;
                        state_q <= DONE;
                    end else if (tmr_tc) begin
                        ack_q    <= 1'b1;
                        rdat_q   <= TO_DATA;
                        toflag_q <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wbs_ack_o     = ack_q;
    assign wbs_dat_o     = rdat_q;
    assign m_cyc_o       = m_cyc_q;
    assign m_stb_o       = m_stb_q;
    assign m_we_o        = m_we_q;
    assign m_sel_o       = m_sel_q;
    assign m_dat_o       = m_dat_q;
    assign m_adr_o       = m_adr_q;
    assign configuration = cfg_q;
    assign timeout_flag  = toflag_q;

endmodule

// File: doc/wb_route_ctrl.md
Name: wb_route_ctrl

Overview:
- Wishbone front-end stage between the management-core slave port and the bot_h_line fan-out/mux.
- Registers each request toward the tiles, holds the 4-bit tile-select `configuration` register, and drives that register into bot_h_line.
- Enforces a response timeout: a tile that never acks returns a fixed error word instead of hanging the core.
- Accepts one outstanding transaction at a time (classic Wishbone, no pipelining).

Parameters:
- CFG_ADDR, 32'h3000_FFFC, byte address of the local config/status register (full 32-bit compare).
- TIMEOUT, 255, cycles in WAIT without a downstream ack before forced completion (legal range 1..65535).
- TO_DATA, 32'hDEAD_BEEF, read data returned on timeout.
- CFG_RESET, 4'd0, reset value of configuration.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  upstream Wishbone strobe, cycle and write-enable.
- wbs_sel_i  in  4  upstream byte selects.
- wbs_dat_i  in  32  upstream write data.
- wbs_adr_i  in  32  upstream address.
- wbs_ack_o  out  1  upstream ack.
- wbs_dat_o  out  32  upstream read data.
- m_stb_o, m_cyc_o, m_we_o  out  1 each  to bot_h_line.
- m_sel_o  out  4  to bot_h_line.
- m_dat_o, m_adr_o  out  32 each  to bot_h_line.
- m_ack_i  in  1  from bot_h_line.
- m_dat_i  in  32  from bot_h_line.
- configuration  out  4  tile select into bot_h_line.
- timeout_flag  out  1  sticky flag: a timeout has occurred.

Behaviour:
- Reset (async assert, sync release): all outputs 0 except configuration = CFG_RESET; state IDLE; timeout counter 0.
- All outputs are registered.
- States: IDLE, LOCAL, WAIT, DONE.
- IDLE, on cyc&stb:
  - adr == CFG_ADDR -> LOCAL.
  - Otherwise latch we/sel/dat/adr into m_*, assert m_cyc_o and m_stb_o -> WAIT. m_* are visible the cycle after the request is sampled.
- LOCAL (one cycle): wbs_ack_o = 1, then -> IDLE.
  - Read data: {23'b0, timeout_flag, 4'b0, configuration}.
  - Write with sel[0] = 1: configuration <= dat[3:0] only if dat[3:0] <= 3; values 4..15 are ignored (configuration unchanged).
  - Write with sel[1] = 1 and dat[8] = 1: clears timeout_flag (write-1-clear).
  - Register updates take effect on the same edge that raises ack.
  - Local latency: request sampled at edge N, ack high in cycle N+1.
- WAIT: m_* held stable; counter increments every cycle.
  - m_ack_i = 1: capture m_dat_i into wbs_dat_o, drop m_cyc/m_stb -> DONE.
  - Else counter == TIMEOUT-1: wbs_dat_o = TO_DATA, set timeout_flag, drop m_* -> DONE.
  - Ack and timeout in the same cycle: the ack wins and timeout_flag is not set.
  - wbs_cyc_i drops (abort): drop m_* next cycle, no upstream ack, counter cleared -> IDLE.
- DONE: wbs_ack_o = 1 for exactly one cycle; counter cleared -> IDLE.
  - Forwarded latency: downstream ack sampled at edge K, upstream ack high in cycle K+1.
  - Round trip with a zero-wait tile: 3 cycles from request to upstream ack.
- wbs_dat_o is 0 except in the ack cycle.
- wbs_ack_o is never asserted in two consecutive cycles.
- A request arriving while not in IDLE is not sampled.
- configuration changes only in LOCAL, so it never changes while m_stb_o = 1.
- Counter width: $clog2(TIMEOUT+1); it never wraps.
- Reset asserted mid-WAIT: m_* drop immediately (async); no ack is issued.

Decomposition:
- Package wb_route_pkg:
  - state enum (IDLE, LOCAL, WAIT, DONE);
  - config register bit positions: CFG_SEL_LSB = 0, CFG_SEL_W = 4, CFG_TOFLAG_BIT = 8;
  - maximum legal configuration value, 3.
- One sub-module, wb_route_timer: clearable up-counter with a terminal-count output, parameterised by TIMEOUT.

Test Plan:
- Config write then read: write 32'h2 to CFG_ADDR, sel = 4'h1 -> ack in the cycle after the request, configuration = 2. Read returns 32'h0000_0002.
- Illegal value: write 32'h7 to CFG_ADDR -> ack asserted, configuration stays 2.
- Forwarded read: read 32'h3000_0010 with the tile acking 2 cycles after m_stb_o rises, m_dat_i = 32'h1234_5678 -> m_adr_o = 32'h3000_0010, wbs_dat_o = 32'h1234_5678, one-cycle ack, 5 cycles from request to ack.
- Timeout: TIMEOUT = 4, tile never acks -> m_stb_o held 4 cycles then dropped. wbs_dat_o = 32'hDEAD_BEEF, ack 1 cycle, timeout_flag = 1. Config read returns 32'h0000_0102 (configuration = 2).
- Ack/timeout tie: with TIMEOUT = 4, m_ack_i rises in the 4th WAIT cycle -> tile data returned, timeout_flag unchanged. Then write 32'h100 with sel = 4'h2 -> flag cleared.
- Abort and reset: drop wbs_cyc_i in WAIT -> m_cyc_o = 0 next cycle, no ack, next request served normally. Assert wb_rst_i mid-WAIT -> all outputs 0 immediately, configuration = CFG_RESET.
